inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch unit; the requesting end of the InstROM interface.
- Drives InstAddress into the combinational InstROM and captures the returned 9-bit instruction into a one-entry output register.
- Presents the registered instruction to decode over a valid/ready handshake.
- Handles start, backpressure, branch redirect/flush and halt detection; raises Done when the program ends.

Parameters:
- A_W, 7, instruction address width (128-entry ROM).
- I_W, 9, instruction width.
- START_ADDR, 7'd0, PC value after reset and on every Start.
- HALT_INST, 9'h1FF, instruction encoding that ends the program.

Ports:
- Clk  input  1  clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  begin fetching at START_ADDR; honoured only in IDLE or HALTED.
- InstAddress  output  A_W  address to InstROM; equals the PC register.
- InstIn  input  I_W  InstROM data for InstAddress, valid in the same cycle.
- InstOut  output  I_W  registered instruction to decode.
- PCOut  output  A_W  address from which InstOut was fetched.
- InstValid  output  1  InstOut/PCOut are valid.
- InstReady  input  1  decode accepts InstOut this cycle.
- Redirect  input  1  branch taken; flush and refetch.
- RedirectTarget  input  A_W  new PC when Redirect=1.
- Done  output  1  program halted; HALT_INST has been consumed.

Behaviour:
- Reset (asynchronous): state=IDLE, PC=START_ADDR, InstOut=0, PCOut=0, InstValid=0, Done=0.
- States: IDLE, FETCH, DRAIN, HALTED.
- Accept condition: acc = InstValid & InstReady.
- Load condition: load = !InstValid | acc.
- IDLE:
  - Start=1 -> FETCH next cycle, PC=START_ADDR.
  - Redirect and InstReady are ignored.
- FETCH, Redirect=0, load=1:
  - InstOut<=InstIn, PCOut<=PC, InstValid<=1, PC<=PC+1.
  - PC+1 wraps 127->0 modulo 2^A_W.
  - If InstIn==HALT_INST: capture it as above, leave PC unchanged, go to DRAIN.
- FETCH, Redirect=0, load=0 (stalled): InstOut, PCOut, InstValid and PC all hold.
- Redirect has priority over load/stall in FETCH and DRAIN:
  - PC<=RedirectTarget, InstValid<=0, state<=FETCH.
  - Same-cycle acc is still a valid handoff to decode; the register is then flushed.
  - Fetch from the target starts in the following cycle, giving a 1-cycle bubble.
- DRAIN:
  - No fetch.
  - On acc: InstValid<=0, Done<=1, state<=HALTED.
  - Until acc: the halt instruction is held.
- HALTED:
  - Done stays 1, InstValid=0, PC frozen.
  - Start=1 -> PC<=START_ADDR, Done<=0, state<=FETCH.
- Start is ignored in FETCH and DRAIN.
- Throughput with InstReady=1: one instruction per cycle.
- Latency: 1 cycle from InstAddress to InstOut.
- Reset asserted mid-operation: outputs go to reset values immediately; any in-flight instruction is discarded.

Test Plan:
- ROM model mem[i]=i (except where noted), Reset, Start pulse, InstReady=1 -> from cycle 2 InstValid=1, (PCOut,InstOut)=(0,0),(1,1),(2,2)...; InstAddress leads PCOut by 1.
- Backpressure: drop InstReady for 3 cycles while PCOut=5 -> InstOut=5, PCOut=5 and InstAddress=6 are held; raising InstReady gives PCOut=6 next cycle with no skip or duplicate.
- Redirect to 0x40 while InstValid=1 and InstReady=0 -> next cycle InstValid=0; cycle after: PCOut=0x40, InstOut=mem[0x40]; old instruction never accepted.
- Halt:
  - Setup: mem[10]=9'h1FF, InstReady held 0 at PCOut=10 for 2 cycles.
  - Required: InstOut=9'h1FF held, InstAddress stays 10, Done=0.
  - Raise InstReady: Done=1 and InstValid=0 next cycle.
  - Then Start: fetch restarts with PCOut=0, Done=0.
- Wrap: Redirect to 127 -> PCOut sequence 127, 0, 1.
- Reset asserted asynchronously mid-stream (PCOut=20) -> InstValid=0, InstAddress=0 and Done=0 without waiting for a clock edge; no fetch until the next Start.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives InstROM addresses and registers the returned
// instruction into a one-entry valid/ready output stage, with redirect and halt.
module inst_fetch #(
  parameter int                 A_W        = 7,
  parameter int                 I_W        = 9,
  parameter logic [A_W-1:0]     START_ADDR = 7'd0,
  parameter logic [I_W-1:0]     HALT_INST  = 9'h1FF
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  output logic [A_W-1:0] InstAddress,
  input  logic [I_W-1:0] InstIn,
  output logic [I_W-1:0] InstOut,
  output logic [A_W-1:0] PCOut,
  output logic           InstValid,
  input  logic           InstReady,
  input  logic           Redirect,
  input  logic [A_W-1:0] RedirectTarget,
  output logic           Done
);

  // state  | meaning
  // IDLE   | waiting for Start after reset
  // FETCH  | fetching one instruction per cycle when the output stage can load
  // DRAIN  | halt instruction captured, waiting for decode to accept it
  // HALTED | program finished, Done high until the next Start
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;

  state_t         state, stateNext;
  logic [A_W-1:0] pc, pcNext;
  logic [I_W-1:0] instOutNext;
  logic [A_W-1:0] pcOutNext;
  logic           validNext, doneNext;
  logic           acc, load;

  assign acc         = InstValid & InstReady;
  assign load        = ~InstValid | acc;
  assign InstAddress = pc;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      pc        <= START_ADDR;
      InstOut   <= '0;
      PCOut     <= '0;
      InstValid <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      InstOut   <= instOutNext;
      PCOut     <= pcOutNext;
      InstValid <= validNext;
      Done      <= doneNext;
    end
  end

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    instOutNext = InstOut;
    pcOutNext   = PCOut;
    validNext   = InstValid;
    doneNext    = Done;
    unique case (state)
      IDLE: begin
        if (Start) begin
          stateNext = FETCH;
          pcNext    = START_ADDR;
        end
      end
      FETCH: begin
        // Redirect wins over a load; a same-cycle accept still hands off first.
        if (Redirect) begin
          pcNext    = RedirectTarget;
          validNext = 1'b0;
        end else if (load) begin
          instOutNext = InstIn;
          pcOutNext   = pc;
          validNext   = 1'b1;
          if (InstIn == HALT_INST) begin
            stateNext = DRAIN;
          end else begin
            pcNext = pc + A_W'(1);
          end
        end
      end
      DRAIN: begin
        if (Redirect) begin
          pcNext    = RedirectTarget;
          validNext = 1'b0;
          stateNext = FETCH;
        end else if (acc) begin
          validNext = 1'b0;
          doneNext  = 1'b1;
          stateNext = HALTED;
        end
      end
      HALTED: begin
        if (Start) begin
          pcNext    = START_ADDR;
          doneNext  = 1'b0;
          stateNext = FETCH;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational ROM model (mem[i]=i by default).
module tb_inst_fetch;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [6:0] InstAddress;
  logic [8:0] InstIn;
  logic [8:0] InstOut;
  logic [6:0] PCOut;
  logic       InstValid;
  logic       InstReady = 1'b0;
  logic       Redirect = 1'b0;
  logic [6:0] RedirectTarget = '0;
  logic       Done;

  logic [8:0] mem [0:127];
  int compared = 0;
  int mismatched = 0;

  assign InstIn = mem[InstAddress];

  inst_fetch dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .InstAddress(InstAddress),
    .InstIn(InstIn), .InstOut(InstOut), .PCOut(PCOut), .InstValid(InstValid),
    .InstReady(InstReady), .Redirect(Redirect), .RedirectTarget(RedirectTarget),
    .Done(Done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    compared++;
    if ({InstValid, Done, InstAddress, PCOut, InstOut} !== {1'b0, 1'b0, 7'd0, 7'd0, 9'd0}) begin
      mismatched++;
      $display("FAIL reset_state: valid=%0b done=%0b addr=%0d pcout=%0d inst=%0h, expected all zero",
               InstValid, Done, InstAddress, PCOut, InstOut);
    end
    Reset = 1'b0;
    tick();
    compared++;
    if (InstValid !== 1'b0 || InstAddress !== 7'd0) begin
      mismatched++;
      $display("FAIL idle_no_fetch: valid=%0b addr=%0d, expected 0/0", InstValid, InstAddress);
    end
  endtask

  task automatic test_stream();
    Start = 1'b1;
    InstReady = 1'b1;
    tick();
    Start = 1'b0;
    compared++;
    if (InstValid !== 1'b0 || InstAddress !== 7'd0) begin
      mismatched++;
      $display("FAIL start_first_cycle: valid=%0b addr=%0d, expected 0/0", InstValid, InstAddress);
    end
    for (int k = 0; k <= 5; k++) begin
      tick();
      compared++;
      if ({InstValid, PCOut, InstOut, InstAddress} !== {1'b1, 7'(k), 9'(k), 7'(k + 1)}) begin
        mismatched++;
        $display("FAIL stream_%0d: valid=%0b pcout=%0d inst=%0h addr=%0d, expected 1/%0d/%0h/%0d",
                 k, InstValid, PCOut, InstOut, InstAddress, k, k, k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    InstReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({InstValid, PCOut, InstOut, InstAddress} !== {1'b1, 7'd5, 9'd5, 7'd6}) begin
        mismatched++;
        $display("FAIL stall_%0d: valid=%0b pcout=%0d inst=%0h addr=%0d, expected 1/5/5/6",
                 k, InstValid, PCOut, InstOut, InstAddress);
      end
    end
    InstReady = 1'b1;
    tick();
    compared++;
    if (PCOut !== 7'd6 || InstOut !== 9'd6 || InstAddress !== 7'd7) begin
      mismatched++;
      $display("FAIL stall_release: pcout=%0d inst=%0h addr=%0d, expected 6/6/7", PCOut, InstOut, InstAddress);
    end
  endtask

  task automatic test_redirect();
    InstReady = 1'b0;
    mem[7'h40] = 9'h0AB;
    Redirect = 1'b1;
    RedirectTarget = 7'h40;
    tick();
    Redirect = 1'b0;
    compared++;
    if (InstValid !== 1'b0 || InstAddress !== 7'h40) begin
      mismatched++;
      $display("FAIL redirect_flush: valid=%0b addr=%0h, expected 0/40", InstValid, InstAddress);
    end
    tick();
    compared++;
    if ({InstValid, PCOut, InstOut} !== {1'b1, 7'h40, 9'h0AB}) begin
      mismatched++;
      $display("FAIL redirect_target: valid=%0b pcout=%0h inst=%0h, expected 1/40/0ab", InstValid, PCOut, InstOut);
    end
    mem[7'h40] = 9'h040;
  endtask

  task automatic test_wrap();
    InstReady = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 7'd127;
    tick();
    Redirect = 1'b0;
    compared++;
    if (InstValid !== 1'b0) begin
      mismatched++;
      $display("FAIL wrap_bubble: valid=%0b, expected 0", InstValid);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({InstValid, PCOut, InstOut} !== {1'b1, 7'(127 + k), 9'((127 + k) % 128)}) begin
        mismatched++;
        $display("FAIL wrap_%0d: valid=%0b pcout=%0d inst=%0h, expected 1/%0d/%0h",
                 k, InstValid, PCOut, InstOut, (127 + k) % 128, (127 + k) % 128);
      end
    end
  endtask

  task automatic test_halt();
    mem[10] = 9'h1FF;
    InstReady = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 7'd8;
    tick();
    Redirect = 1'b0;
    tick();
    tick();
    compared++;
    if (PCOut !== 7'd9 || InstAddress !== 7'd10) begin
      mismatched++;
      $display("FAIL halt_setup: pcout=%0d addr=%0d, expected 9/10", PCOut, InstAddress);
    end
    tick();
    InstReady = 1'b0;
    compared++;
    if ({InstValid, PCOut, InstOut, InstAddress} !== {1'b1, 7'd10, 9'h1FF, 7'd10}) begin
      mismatched++;
      $display("FAIL halt_capture: valid=%0b pcout=%0d inst=%0h addr=%0d, expected 1/10/1ff/10",
               InstValid, PCOut, InstOut, InstAddress);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      compared++;
      if ({InstValid, Done, InstOut, InstAddress} !== {1'b1, 1'b0, 9'h1FF, 7'd10}) begin
        mismatched++;
        $display("FAIL halt_hold_%0d: valid=%0b done=%0b inst=%0h addr=%0d, expected 1/0/1ff/10",
                 k, InstValid, Done, InstOut, InstAddress);
      end
    end
    InstReady = 1'b1;
    tick();
    compared++;
    if (Done !== 1'b1 || InstValid !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_done: done=%0b valid=%0b, expected 1/0", Done, InstValid);
    end
    tick();
    compared++;
    if (Done !== 1'b1 || InstValid !== 1'b0 || InstAddress !== 7'd10) begin
      mismatched++;
      $display("FAIL halted_hold: done=%0b valid=%0b addr=%0d, expected 1/0/10", Done, InstValid, InstAddress);
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    compared++;
    if (Done !== 1'b0 || InstAddress !== 7'd0) begin
      mismatched++;
      $display("FAIL restart: done=%0b addr=%0d, expected 0/0", Done, InstAddress);
    end
    tick();
    compared++;
    if ({InstValid, PCOut, InstOut} !== {1'b1, 7'd0, 9'd0}) begin
      mismatched++;
      $display("FAIL restart_fetch: valid=%0b pcout=%0d inst=%0h, expected 1/0/0", InstValid, PCOut, InstOut);
    end
    mem[10] = 9'd10;
  endtask

  task automatic test_async_reset();
    InstReady = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 7'd18;
    tick();
    Redirect = 1'b0;
    tick();
    tick();
    tick();
    compared++;
    if (PCOut !== 7'd20) begin
      mismatched++;
      $display("FAIL pre_reset: pcout=%0d, expected 20", PCOut);
    end
    #2;
    Reset = 1'b1;
    #1;
    compared++;
    if ({InstValid, InstAddress, Done, PCOut} !== {1'b0, 7'd0, 1'b0, 7'd0}) begin
      mismatched++;
      $display("FAIL async_reset: valid=%0b addr=%0d done=%0b pcout=%0d, expected 0/0/0/0",
               InstValid, InstAddress, Done, PCOut);
    end
    tick();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if (InstValid !== 1'b0 || InstAddress !== 7'd0) begin
        mismatched++;
        $display("FAIL post_reset_idle_%0d: valid=%0b addr=%0d, expected 0/0", k, InstValid, InstAddress);
      end
    end
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    compared++;
    if ({InstValid, PCOut, InstOut} !== {1'b1, 7'd1, 9'd1}) begin
      mismatched++;
      $display("FAIL post_reset_start: valid=%0b pcout=%0d inst=%0h, expected 1/1/1", InstValid, PCOut, InstOut);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 9'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
